// File: rtl/pipelined_multi_operand_adder_if.sv
// pipelined_multi_operand_adder_if: valid/ready operand and result stream bundle.
// out_ovf exists only when MOA_OVF_EN is defined.
`default_nettype none

interface pipelined_multi_operand_adder_if #(
  parameter int WIDTH = 8,
  parameter int N_OPS = 3,
  parameter int OUT_W = WIDTH + $clog2(N_OPS)
);
  logic                   in_valid;
  logic                   in_ready;
  logic [N_OPS*WIDTH-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_sum;
`ifdef MOA_OVF_EN
  logic                   out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum
  );
`endif
endinterface

`default_nettype wire

// File: rtl/pipelined_multi_operand_adder.sv
// pipelined_multi_operand_adder: registered binary adder tree summing N_OPS operands,
// globally stalled valid/ready pipeline. Optional MOA_OVF_EN adds a truncation flag.
`default_nettype none

module pipelined_multi_operand_adder #(
  parameter int WIDTH = 8,
  parameter int N_OPS = 3,
  parameter int OUT_W = WIDTH + $clog2(N_OPS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  pipelined_multi_operand_adder_if.slave bus
);

  localparam int LAT    = (N_OPS <= 1) ? 1 : $clog2(N_OPS);
  localparam int FULL_W = (N_OPS <= 1) ? WIDTH : WIDTH + $clog2(N_OPS);

  // Number of partial sums present at tree level k (level 0 = raw operands).
  function automatic int cnt_at(input int k);
    return (N_OPS + (1 << k) - 1) >> k;
  endfunction

  // Register width of pipeline stage s; a single operand never grows.
  function automatic int sw_at(input int s);
    return (N_OPS <= 1) ? WIDTH : WIDTH + s + 1;
  endfunction

  logic             w_adv;
  logic [LAT-1:0]   r_vld;
  logic [FULL_W-1:0] w_full;

  assign w_adv = !r_vld[LAT-1] || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (w_adv) begin
      r_vld[0] <= bus.in_valid;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  for (genvar s = 0; s < LAT; s++) begin : g_stage
    localparam int IW   = (s == 0) ? WIDTH : sw_at(s - 1);
    localparam int NIN  = cnt_at(s);
    localparam int NOUT = cnt_at(s + 1);
    localparam int SW   = sw_at(s);

    logic [NIN*IW-1:0]  w_in;
    logic [NOUT*SW-1:0] w_next;
    logic [NOUT*SW-1:0] r_data;

    if (s == 0) begin : g_src_in
      assign w_in = bus.in_data;
    end else begin : g_src_prev
      assign w_in = g_stage[s-1].r_data;
    end

    // Pair (2j, 2j+1); an odd leftover is zero-extended straight through.
    for (genvar j = 0; j < NOUT; j++) begin : g_node
      if (2*j + 1 < NIN) begin : g_pair
        assign w_next[j*SW +: SW] = SW'(w_in[2*j*IW +: IW]) + SW'(w_in[(2*j+1)*IW +: IW]);
      end else begin : g_pass
        assign w_next[j*SW +: SW] = SW'(w_in[2*j*IW +: IW]);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data <= '0;
      end else if (w_adv) begin
        r_data <= w_next;
      end
    end
  end

  assign w_full        = g_stage[LAT-1].r_data;
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_vld[LAT-1];
  assign bus.out_sum   = w_full[OUT_W-1:0];

`ifdef MOA_OVF_EN
  if (OUT_W < FULL_W) begin : g_ovf
    assign bus.out_ovf = |w_full[FULL_W-1:OUT_W];
  end else begin : g_no_ovf
    assign bus.out_ovf = 1'b0;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipelined_multi_operand_adder.sv
// tb_pipelined_multi_operand_adder: directed vector table plus stall/reset sequences
// over three adder configurations (and an OUT_W=9 instance when MOA_OVF_EN is defined).
`default_nettype none

module tb_pipelined_multi_operand_adder;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pipelined_multi_operand_adder_if #(.WIDTH(8), .N_OPS(3), .OUT_W(10)) bm ();
  pipelined_multi_operand_adder_if #(.WIDTH(4), .N_OPS(1), .OUT_W(4))  b1 ();
  pipelined_multi_operand_adder_if #(.WIDTH(8), .N_OPS(5), .OUT_W(11)) b5 ();

  pipelined_multi_operand_adder #(.WIDTH(8), .N_OPS(3), .OUT_W(10)) u_main (
    .clk(clk), .rst_n(rst_n), .bus(bm.slave));
  pipelined_multi_operand_adder #(.WIDTH(4), .N_OPS(1), .OUT_W(4)) u_n1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));
  pipelined_multi_operand_adder #(.WIDTH(8), .N_OPS(5), .OUT_W(11)) u_n5 (
    .clk(clk), .rst_n(rst_n), .bus(b5.slave));

`ifdef MOA_OVF_EN
  pipelined_multi_operand_adder_if #(.WIDTH(8), .N_OPS(3), .OUT_W(9)) bo ();
  pipelined_multi_operand_adder #(.WIDTH(8), .N_OPS(3), .OUT_W(9)) u_ovf (
    .clk(clk), .rst_n(rst_n), .bus(bo.slave));
`endif

  typedef struct {
    logic [23:0] in;
    logic [9:0]  exp;
  } vec_t;

  localparam int NV = 8;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{{8'd0,   8'd0,   8'd0},   10'd0};
    tbl[1] = '{{8'd255, 8'd255, 8'd255}, 10'd765};
    tbl[2] = '{{8'd3,   8'd2,   8'd1},   10'd6};
    tbl[3] = '{{8'd0,   8'd128, 8'd128}, 10'd256};
    tbl[4] = '{{8'd100, 8'd100, 8'd100}, 10'd300};
    tbl[5] = '{{8'd1,   8'd0,   8'd255}, 10'd256};
    tbl[6] = '{{8'd255, 8'd0,   8'd0},   10'd255};
    tbl[7] = '{{8'd51,  8'd34,  8'd17},  10'd102};

    rst_n = 1'b0;
    bm.in_valid = 1'b0; bm.in_data = '0; bm.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b1;
    b5.in_valid = 1'b0; b5.in_data = '0; b5.out_ready = 1'b1;
`ifdef MOA_OVF_EN
    bo.in_valid = 1'b0; bo.in_data = '0; bo.out_ready = 1'b1;
`endif
    tick(); tick();
    check("rst_out_valid", 32'(bm.out_valid), 0);
    check("rst_out_sum",   32'(bm.out_sum),   0);
    check("rst_in_ready",  32'(bm.in_ready),  1);
    rst_n = 1'b1;
    tick();

    // Back-to-back stream: result i appears two edges after it is driven.
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) begin
        bm.in_valid = 1'b1;
        bm.in_data  = tbl[i].in;
      end else begin
        bm.in_valid = 1'b0;
      end
      check("stream_in_ready", 32'(bm.in_ready), 1);
      tick();
      if (i == 0) begin
        check("stream_first_idle", 32'(bm.out_valid), 0);
      end else begin
        check("stream_valid", 32'(bm.out_valid), 1);
        check("stream_sum",   32'(bm.out_sum), 32'(tbl[i-1].exp));
`ifdef MOA_OVF_EN
        check("stream_ovf_full_width", 32'(bm.out_ovf), 0);
`endif
      end
    end
    tick();
    check("stream_drained", 32'(bm.out_valid), 0);

    // Exact latency on all three configurations.
    bm.in_valid = 1'b1; bm.in_data = {3{8'hFF}};
    b1.in_valid = 1'b1; b1.in_data = 4'd9;
    b5.in_valid = 1'b1; b5.in_data = {5{8'hFF}};
    tick();
    bm.in_valid = 1'b0; b1.in_valid = 1'b0;
    b5.in_data = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    check("lat_main_t1_idle", 32'(bm.out_valid), 0);
    check("n1_valid",         32'(b1.out_valid), 1);
    check("n1_sum",           32'(b1.out_sum),   9);
    check("n5_t1_idle",       32'(b5.out_valid), 0);
    tick();
    b5.in_valid = 1'b0;
    check("lat_main_valid", 32'(bm.out_valid), 1);
    check("lat_main_sum",   32'(bm.out_sum),   765);
    check("n1_bubble",      32'(b1.out_valid), 0);
    check("n5_t2_idle",     32'(b5.out_valid), 0);
    tick();
    check("lat_main_t3_idle", 32'(bm.out_valid), 0);
    check("n5_valid",         32'(b5.out_valid), 1);
    check("n5_sum_max",       32'(b5.out_sum),   1275);
    tick();
    check("n5_sum_second", 32'(b5.out_sum), 15);
    tick();
    check("n5_drained", 32'(b5.out_valid), 0);

    // Output stall: result held, input blocked, then drained in order.
    bm.out_ready = 1'b0;
    bm.in_valid  = 1'b1; bm.in_data = {8'd30, 8'd20, 8'd10};
    tick();
    bm.in_data = {8'd1, 8'd1, 8'd1};
    check("stall_fill_ready", 32'(bm.in_ready), 1);
    tick();
    bm.in_data = {8'd5, 8'd5, 8'd5};
    check("stall_valid",    32'(bm.out_valid), 1);
    check("stall_sum",      32'(bm.out_sum),   60);
    check("stall_in_ready", 32'(bm.in_ready),  0);
    tick(); tick();
    check("stall_hold_valid", 32'(bm.out_valid), 1);
    check("stall_hold_sum",   32'(bm.out_sum),   60);
    check("stall_hold_ready", 32'(bm.in_ready),  0);
    bm.out_ready = 1'b1;
    #1;
    check("unstall_in_ready", 32'(bm.in_ready), 1);
    tick();
    bm.in_valid = 1'b0;
    check("drain_sum_b", 32'(bm.out_sum), 3);
    tick();
    check("drain_valid_c", 32'(bm.out_valid), 1);
    check("drain_sum_c",   32'(bm.out_sum),   15);
    tick();
    check("drain_idle", 32'(bm.out_valid), 0);

    // Asynchronous reset with two vectors in flight and the output stalled.
    bm.out_ready = 1'b0;
    bm.in_valid  = 1'b1; bm.in_data = {3{8'd7}};
    tick();
    bm.in_data = {3{8'd9}};
    tick();
    bm.in_valid = 1'b0;
    check("prerst_valid", 32'(bm.out_valid), 1);
    check("prerst_sum",   32'(bm.out_sum),   21);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid",    32'(bm.out_valid), 0);
    check("async_rst_sum",      32'(bm.out_sum),   0);
    check("async_rst_in_ready", 32'(bm.in_ready),  1);
    tick();
    rst_n = 1'b0;
    bm.out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_rst_no_stale", 32'(bm.out_valid), 0);
    end

`ifdef MOA_OVF_EN
    bo.in_valid = 1'b1; bo.in_data = {3{8'hFF}};
    tick();
    bo.in_data = {3{8'd100}};
    tick();
    bo.in_valid = 1'b0;
    check("ovf_trunc_sum",  32'(bo.out_sum), 32'h0FD);
    check("ovf_trunc_flag", 32'(bo.out_ovf), 1);
    tick();
    check("ovf_fit_sum",  32'(bo.out_sum), 300);
    check("ovf_fit_flag", 32'(bo.out_ovf), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipelined_multi_operand_adder.md
Name: pipelined_multi_operand_adder

Overview:
Parametrised, pipelined successor to the team's fixed three-operand ripple adder. Sums N_OPS unsigned WIDTH-bit operands through a registered binary adder tree with a valid/ready stream interface on both sides. Used wherever multi-term sums (checksums, partial-product reduction, filter taps) must meet timing at clock rate instead of as one long combinational chain.

Parameters:
WIDTH, 8, bit width of each unsigned operand (>=1)
N_OPS, 3, number of operands summed per transaction (>=1)
OUT_W, WIDTH+$clog2(N_OPS), result width; must be <= WIDTH+$clog2(N_OPS) (N_OPS=1 gives WIDTH); smaller values truncate MSBs
LAT (localparam), max(1,$clog2(N_OPS)), pipeline depth in cycles = number of tree levels

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset; one clock, asynchronous assert, active-low
in_valid  input  1  operand vector valid
in_ready  output  1  block can accept this cycle
in_data  input  N_OPS*WIDTH  packed operands; operand i at [i*WIDTH +: WIDTH]
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_sum  output  OUT_W  sum of the N_OPS operands, low OUT_W bits
out_ovf  output  1  present only with MOA_OVF_EN (see below)

Behaviour:
- Arithmetic: full-precision sum width FULL_W = WIDTH+$clog2(N_OPS) (WIDTH if N_OPS=1); no wrap possible at FULL_W. out_sum = full_sum[OUT_W-1:0].
- Tree: level k pairs adjacent partial sums from level k-1 (index 2j,2j+1); odd leftover passes through unchanged; each level registered. Level-k register width WIDTH+k.
- Pipeline: LAT stages, each with a valid bit. Global advance: adv = !out_valid || out_ready. When adv, every stage loads from the previous one (stage 0 loads in_data, valid = in_valid). When !adv, all stages hold.
- in_ready = adv (combinational from out_valid/out_ready; in_valid must not depend on in_ready).
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Latency: a vector accepted in cycle t appears on out_valid/out_sum in cycle t+LAT when no stall; each stall cycle adds one.
- Throughput: 1 result/cycle with out_ready held high.
- Bubbles propagate as invalid stages; they are not collapsed (stall is global).
- out_valid/out_sum stable while out_valid && !out_ready.
- Reset (rst_n low, any time, including mid-transaction): all stage valids cleared, all data registers cleared to 0; out_valid=0, out_sum=0, in_ready=1 during and after reset; in-flight vectors discarded.
- Simultaneous out-transfer and in-transfer in the same cycle is legal and required for full throughput.
- Data registers may update on invalid stages; only valid-qualified outputs are checked.

Optional Feature:
MOA_OVF_EN: when defined, adds output out_ovf (1 bit), registered alongside out_sum: out_ovf=1 iff full_sum[FULL_W-1:OUT_W] != 0 (always 0 when OUT_W=FULL_W); reset value 0; valid only with out_valid. When not defined, the port does not exist and truncation is silent.

Test Plan:
- Defaults (WIDTH=8,N_OPS=3,OUT_W=10,LAT=2), out_ready=1: send {255,255,255} -> out_sum=765 (0x2FD) exactly 2 cycles after acceptance.
- Back-to-back stream of 1000 random vectors, out_ready=1 -> in_ready constant 1, outputs in order, one per cycle, all equal reference sums.
- Random out_ready (50%) and random in_valid gaps -> no lost/duplicated results; out_sum held stable while out_valid && !out_ready; in_ready=0 only when out_valid && !out_ready.
- N_OPS=1, WIDTH=4: send 9 -> out_sum=9 after 1 cycle; N_OPS=5, WIDTH=8: {255 x5} -> 1275 after LAT=3 cycles.
- Assert rst_n low for one cycle with 2 vectors in flight and output stalled -> out_valid=0, out_sum=0 immediately (async), in_ready=1; no stale result appears afterward.
- MOA_OVF_EN with OUT_W=9, defaults otherwise: {255,255,255} -> out_sum=0x0FD, out_ovf=1; {100,100,100} -> out_sum=300, out_ovf=0.
